// File: rtl/latency_pipe_sched_if.sv
// Handshake bundle for latency_pipe_sched: two requesters,
// the external delay datapath, and the result consumer.
interface latency_pipe_sched_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0ValidIn;
  logic [DATA_WIDTH-1:0] req0DataIn;
  logic                  req0ReadyOut;
  logic                  req1ValidIn;
  logic [DATA_WIDTH-1:0] req1DataIn;
  logic                  req1ReadyOut;
  logic [DATA_WIDTH-1:0] pipeDataOut;
  logic [DATA_WIDTH-1:0] pipeDataIn;
  logic                  rspValidOut;
  logic [DATA_WIDTH-1:0] rspDataOut;
  logic                  rspIdOut;
  logic                  rspReadyIn;
  logic                  busyOut;

  modport master (
    output req0ValidIn, req0DataIn,
    output req1ValidIn, req1DataIn,
    output pipeDataIn, rspReadyIn,
    input  req0ReadyOut, req1ReadyOut,
    input  pipeDataOut, rspValidOut,
    input  rspDataOut, rspIdOut, busyOut
  );

  modport slave (
    input  req0ValidIn, req0DataIn,
    input  req1ValidIn, req1DataIn,
    input  pipeDataIn, rspReadyIn,
    output req0ReadyOut, req1ReadyOut,
    output pipeDataOut, rspValidOut,
    output rspDataOut, rspIdOut, busyOut
  );
endinterface

// File: rtl/latency_pipe_sched.sv
// Round-robin issue into a fixed-latency datapath with a
// credit-guarded result FIFO that preserves issue order.
module latency_pipe_sched #(
  parameter int LATENCY    = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic clkIn,
  input logic rstIn,
  latency_pipe_sched_if.slave bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                  last_gnt;
  logic [CW-1:0]         credits;
  logic [CW-1:0]         occ;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LATENCY-1:0]    stg_vld;
  logic [LATENCY-1:0]    stg_id;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_id;

  logic                  win0;
  logic                  win1;
  logic                  can_issue;
  logic                  acc0;
  logic                  acc1;
  logic                  accept;
  logic                  wr_en;
  logic                  pop;
  logic                  empty;
  logic                  full;
  logic [DATA_WIDTH-1:0] pipe_data;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits only drop on the cycle after a pop: the count is registered.
  assign can_issue = rstIn & (credits < CW'(FIFO_DEPTH));
  assign win0      = bus.req0ValidIn & (~bus.req1ValidIn | last_gnt);
  assign win1      = bus.req1ValidIn & (~bus.req0ValidIn | ~last_gnt);
  assign acc0      = win0 & can_issue;
  assign acc1      = win1 & can_issue;
  assign accept    = acc0 | acc1;

  assign empty = (occ == '0);
  assign full  = (occ == CW'(FIFO_DEPTH));
  assign wr_en = stg_vld[LATENCY-1];
  assign pop   = ~empty & bus.rspReadyIn;

  always_comb begin
    pipe_data = '0;
    unique case (1'b1)
      acc0:    pipe_data = bus.req0DataIn;
      acc1:    pipe_data = bus.req1DataIn;
      default: ;
    endcase
  end

  assign bus.req0ReadyOut = acc0;
  assign bus.req1ReadyOut = acc1;
  assign bus.pipeDataOut  = pipe_data;
  assign bus.rspValidOut  = ~empty;
  assign bus.rspDataOut   = empty ? '0 : mem[rd_ptr];
  assign bus.rspIdOut     = ~empty & mem_id[rd_ptr];
  assign bus.busyOut      = (|stg_vld) | ~empty;

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      last_gnt <= 1'b1;
      credits  <= '0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      stg_vld  <= '0;
      stg_id   <= '0;
      mem_id   <= '0;
    end else begin
      if (accept)
        last_gnt <= acc1;
      credits <= credits + CW'(accept) - CW'(pop);
      occ     <= occ + CW'(wr_en) - CW'(pop);
      stg_vld[0] <= accept;
      stg_id[0]  <= acc1;
      for (int i = 1; i < LATENCY; i++) begin
        stg_vld[i] <= stg_vld[i-1];
        stg_id[i]  <= stg_id[i-1];
      end
      if (wr_en) begin
        wr_ptr         <= nxt(wr_ptr);
        mem_id[wr_ptr] <= stg_id[LATENCY-1];
      end
      if (pop)
        rd_ptr <= nxt(rd_ptr);
    end
  end

  // Payload needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clkIn) begin
    if (wr_en)
      mem[wr_ptr] <= bus.pipeDataIn;
  end

  wr_full_chk: assert property (
    @(posedge clkIn) disable iff (!rstIn) !(wr_en && full)
  );

endmodule

// File: tb/tb_latency_pipe_sched.sv
// Directed bench for latency_pipe_sched with an external
// LATENCY-deep delay line standing in for the datapath.
module tb_latency_pipe_sched;

  localparam int LAT   = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  latency_pipe_sched_if #(.DATA_WIDTH(DW)) bus ();

  latency_pipe_sched #(
    .LATENCY(LAT),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clkIn(clk),
    .rstIn(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] dly [LAT];
  always @(posedge clk) begin
    dly[0] <= bus.pipeDataOut;
    for (int i = 1; i < LAT; i++)
      dly[i] <= dly[i-1];
  end
  assign bus.pipeDataIn = dly[LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0ValidIn = 1'b0;
    bus.req1ValidIn = 1'b0;
    bus.req0DataIn  = '0;
    bus.req1DataIn  = '0;
    bus.rspReadyIn  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req0ValidIn = 1'b1;
    bus.req1ValidIn = 1'b1;
    bus.req0DataIn  = 32'h1111_1111;
    bus.req1DataIn  = 32'h2222_2222;
    bus.rspReadyIn  = 1'b1;
    step();
    step();
    @(negedge clk);
    total++;
    if (bus.req0ReadyOut !== 1'b0 || bus.req1ReadyOut !== 1'b0) begin
      bad++;
      $display("FAIL rst_ready: got %b%b want 00",
               bus.req0ReadyOut, bus.req1ReadyOut);
    end
    total++;
    if (bus.rspValidOut !== 1'b0) begin
      bad++;
      $display("FAIL rst_rspvalid: got %b want 0", bus.rspValidOut);
    end
    total++;
    if (bus.rspDataOut !== '0 || bus.rspIdOut !== 1'b0) begin
      bad++;
      $display("FAIL rst_rsp: got %h/%b want 0/0",
               bus.rspDataOut, bus.rspIdOut);
    end
    total++;
    if (bus.pipeDataOut !== '0) begin
      bad++;
      $display("FAIL rst_pipe: got %h want 0", bus.pipeDataOut);
    end
    total++;
    if (bus.busyOut !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy: got %b want 0", bus.busyOut);
    end
    step();
    idle_inputs();
    rst_n = 1'b1;
  endtask

  // Starts in the first cycle after reset release.
  task automatic test_single();
    bus.req0ValidIn = 1'b1;
    bus.req0DataIn  = 32'hA5A5_A5A5;
    bus.rspReadyIn  = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req0ReadyOut !== 1'b1 || bus.req1ReadyOut !== 1'b0) begin
      bad++;
      $display("FAIL single_ready: got %b%b want 10",
               bus.req0ReadyOut, bus.req1ReadyOut);
    end
    total++;
    if (bus.pipeDataOut !== 32'hA5A5_A5A5) begin
      bad++;
      $display("FAIL single_pipe: got %h want a5a5a5a5", bus.pipeDataOut);
    end
    step();
    bus.req0ValidIn = 1'b0;
    bus.req0DataIn  = '0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      total++;
      if (bus.rspValidOut !== 1'b0 || bus.busyOut !== 1'b1 ||
          bus.pipeDataOut !== '0) begin
        bad++;
        $display("FAIL single_wait%0d: got v=%b busy=%b pipe=%h want 0 1 0",
                 k, bus.rspValidOut, bus.busyOut, bus.pipeDataOut);
      end
      step();
    end
    @(negedge clk);
    total++;
    if (bus.rspValidOut !== 1'b1 || bus.rspDataOut !== 32'hA5A5_A5A5 ||
        bus.rspIdOut !== 1'b0) begin
      bad++;
      $display("FAIL single_rsp: got v=%b d=%h id=%b want 1 a5a5a5a5 0",
               bus.rspValidOut, bus.rspDataOut, bus.rspIdOut);
    end
    step();
    @(negedge clk);
    total++;
    if (bus.busyOut !== 1'b0 || bus.rspValidOut !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: got busy=%b v=%b want 0 0",
               bus.busyOut, bus.rspValidOut);
    end
    step();
  endtask

  task automatic test_contention();
    logic [DW-1:0] exp_d [$];
    logic          exp_i [$];
    logic          g0;
    int            n;
    do_reset();
    bus.rspReadyIn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.req0ValidIn = 1'b1;
      bus.req1ValidIn = 1'b1;
      bus.req0DataIn  = 32'h100 + k;
      bus.req1DataIn  = 32'h200 + k;
      g0 = (k % 2 == 0);
      @(negedge clk);
      total++;
      if (bus.req0ReadyOut !== g0 || bus.req1ReadyOut !== !g0) begin
        bad++;
        $display("FAIL cont_grant%0d: got %b%b want %b%b", k,
                 bus.req0ReadyOut, bus.req1ReadyOut, g0, !g0);
      end
      exp_d.push_back(g0 ? 32'h100 + k : 32'h200 + k);
      exp_i.push_back(!g0);
      total++;
      if (bus.pipeDataOut !== exp_d[k]) begin
        bad++;
        $display("FAIL cont_pipe%0d: got %h want %h", k,
                 bus.pipeDataOut, exp_d[k]);
      end
      step();
    end
    idle_inputs();
    bus.rspReadyIn = 1'b1;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.rspValidOut) begin
        total++;
        if (n >= 4) begin
          bad++;
          $display("FAIL cont_extra: got %h want none", bus.rspDataOut);
        end else if (bus.rspDataOut !== exp_d[n] ||
                     bus.rspIdOut !== exp_i[n]) begin
          bad++;
          $display("FAIL cont_rsp%0d: got %h/%b want %h/%b", n,
                   bus.rspDataOut, bus.rspIdOut, exp_d[n], exp_i[n]);
        end
        n++;
      end
      step();
    end
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL cont_count: got %0d want 4", n);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_d [$];
    logic [DW-1:0] head;
    int            n;
    idle_inputs();
    bus.req0ValidIn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.req0DataIn = 32'h3000 + k;
      @(negedge clk);
      total++;
      if (bus.req0ReadyOut !== (k < 4)) begin
        bad++;
        $display("FAIL bp_ready%0d: got %b want %b", k,
                 bus.req0ReadyOut, (k < 4));
      end
      if (k < 4)
        exp_d.push_back(32'h3000 + k);
      if (k >= 10) begin
        total++;
        if (bus.rspValidOut !== 1'b1 || bus.rspDataOut !== 32'h3000) begin
          bad++;
          $display("FAIL bp_hold%0d: got v=%b d=%h want 1 3000", k,
                   bus.rspValidOut, bus.rspDataOut);
        end
      end
      step();
    end
    bus.rspReadyIn = 1'b1;
    bus.req0DataIn = 32'h3014;
    @(negedge clk);
    head = exp_d.pop_front();
    total++;
    if (bus.req0ReadyOut !== 1'b0 || bus.rspDataOut !== head) begin
      bad++;
      $display("FAIL bp_pop: got rdy=%b d=%h want 0 %h",
               bus.req0ReadyOut, bus.rspDataOut, head);
    end
    step();
    bus.rspReadyIn = 1'b0;
    bus.req0DataIn = 32'h3015;
    @(negedge clk);
    total++;
    if (bus.req0ReadyOut !== 1'b1 || bus.rspDataOut !== exp_d[0]) begin
      bad++;
      $display("FAIL bp_refill: got rdy=%b d=%h want 1 %h",
               bus.req0ReadyOut, bus.rspDataOut, exp_d[0]);
    end
    exp_d.push_back(32'h3015);
    step();
    bus.req0DataIn = 32'h3016;
    @(negedge clk);
    total++;
    if (bus.req0ReadyOut !== 1'b0) begin
      bad++;
      $display("FAIL bp_once: got %b want 0", bus.req0ReadyOut);
    end
    step();
    idle_inputs();
    bus.rspReadyIn = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.rspValidOut) begin
        total++;
        if (n >= 4) begin
          bad++;
          $display("FAIL bp_extra: got %h want none", bus.rspDataOut);
        end else if (bus.rspDataOut !== exp_d[n] ||
                     bus.rspIdOut !== 1'b0) begin
          bad++;
          $display("FAIL bp_drain%0d: got %h/%b want %h/0", n,
                   bus.rspDataOut, bus.rspIdOut, exp_d[n]);
        end
        n++;
      end
      step();
    end
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL bp_count: got %0d want 4", n);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [$];
    logic          er;
    int            n;
    idle_inputs();
    n = 0;
    for (int k = 0; k < 50; k++) begin
      bus.req1ValidIn = (k < 24);
      bus.req1DataIn  = 32'h4000 + k;
      bus.rspReadyIn  = 1'b1;
      @(negedge clk);
      if (k < 24) begin
        er = (k % 10 < 4);
        total++;
        if (bus.req1ReadyOut !== er || bus.req0ReadyOut !== 1'b0) begin
          bad++;
          $display("FAIL b2b_ready%0d: got %b%b want 0%b", k,
                   bus.req0ReadyOut, bus.req1ReadyOut, er);
        end
        if (er)
          exp_d.push_back(32'h4000 + k);
      end
      if (bus.rspValidOut) begin
        total++;
        if (n >= 12) begin
          bad++;
          $display("FAIL b2b_extra: got %h want none", bus.rspDataOut);
        end else if (bus.rspDataOut !== exp_d[n] ||
                     bus.rspIdOut !== 1'b1) begin
          bad++;
          $display("FAIL b2b_rsp%0d: got %h/%b want %h/1", n,
                   bus.rspDataOut, bus.rspIdOut, exp_d[n]);
        end
        n++;
      end
      step();
    end
    total++;
    if (n !== 12) begin
      bad++;
      $display("FAIL b2b_count: got %0d want 12", n);
    end
  endtask

  task automatic test_midflight_reset();
    idle_inputs();
    bus.rspReadyIn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.req0ValidIn = 1'b1;
      bus.req0DataIn  = 32'h6000 + k;
      @(negedge clk);
      total++;
      if (bus.req0ReadyOut !== 1'b1) begin
        bad++;
        $display("FAIL mid_issue%0d: got %b want 1", k, bus.req0ReadyOut);
      end
      step();
    end
    bus.req0ValidIn = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busyOut !== 1'b0 || bus.rspValidOut !== 1'b0) begin
      bad++;
      $display("FAIL mid_inrst: got busy=%b v=%b want 0 0",
               bus.busyOut, bus.rspValidOut);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (bus.rspValidOut !== 1'b0 || bus.busyOut !== 1'b0) begin
        bad++;
        $display("FAIL mid_after%0d: got v=%b busy=%b want 0 0", c,
                 bus.rspValidOut, bus.busyOut);
      end
      step();
    end
  endtask

  task automatic test_wrap();
    logic [31:0]   pat;
    logic [DW-1:0] prev_d;
    logic          prev_i;
    logic          prev_hold;
    logic          cid;
    logic          rdy;
    int            sent;
    int            rcv;
    pat       = 32'b1011_0010_0110_1110_0101_1001_0011_0100;
    sent      = 0;
    rcv       = 0;
    prev_hold = 1'b0;
    prev_d    = '0;
    prev_i    = 1'b0;
    idle_inputs();
    for (int k = 0; k < 300 && rcv < 3 * DEPTH; k++) begin
      cid = sent[0];
      bus.req0ValidIn = (sent < 3 * DEPTH) && !cid;
      bus.req1ValidIn = (sent < 3 * DEPTH) && cid;
      bus.req0DataIn  = 32'h5000 + sent;
      bus.req1DataIn  = 32'h5000 + sent;
      bus.rspReadyIn  = pat[k % 32];
      @(negedge clk);
      if (prev_hold) begin
        total++;
        if (bus.rspValidOut !== 1'b1 || bus.rspDataOut !== prev_d ||
            bus.rspIdOut !== prev_i) begin
          bad++;
          $display("FAIL wrap_hold%0d: got %b %h/%b want 1 %h/%b", k,
                   bus.rspValidOut, bus.rspDataOut, bus.rspIdOut,
                   prev_d, prev_i);
        end
      end
      rdy = cid ? bus.req1ReadyOut : bus.req0ReadyOut;
      if (sent < 3 * DEPTH && rdy) begin
        total++;
        if (bus.pipeDataOut !== 32'h5000 + sent) begin
          bad++;
          $display("FAIL wrap_pipe%0d: got %h want %h", sent,
                   bus.pipeDataOut, 32'h5000 + sent);
        end
        sent++;
      end
      if (bus.rspValidOut && bus.rspReadyIn) begin
        total++;
        if (bus.rspDataOut !== 32'h5000 + rcv ||
            bus.rspIdOut !== rcv[0]) begin
          bad++;
          $display("FAIL wrap_rsp%0d: got %h/%b want %h/%b", rcv,
                   bus.rspDataOut, bus.rspIdOut, 32'h5000 + rcv, rcv[0]);
        end
        rcv++;
      end
      prev_hold = bus.rspValidOut && !bus.rspReadyIn;
      prev_d    = bus.rspDataOut;
      prev_i    = bus.rspIdOut;
      step();
    end
    total++;
    if (sent !== 3 * DEPTH || rcv !== 3 * DEPTH) begin
      bad++;
      $display("FAIL wrap_count: got sent=%0d rcv=%0d want %0d %0d",
               sent, rcv, 3 * DEPTH, 3 * DEPTH);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_midflight_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/latency_pipe_sched.md
LATENCY_PIPE_SCHED -- requirements
Module: latency_pipe_sched

Interface
REQ-001 The block SHALL take parameter LATENCY, default 8, as the fixed cycle latency of the attached delay datapath (LATENCY >= 1).
REQ-002 The block SHALL take parameter DATA_WIDTH, default 32, as the operand and result width.
REQ-003 The block SHALL take parameter FIFO_DEPTH, default 4, as the result FIFO entry count (FIFO_DEPTH >= 1).
REQ-004 The block SHALL have one clock, clkIn, and one reset, rstIn, which is asynchronous and active-low.
REQ-005 clkIn  input  1  clock; all state SHALL update on its rising edge.
REQ-006 rstIn  input  1  asynchronous active-low reset.
REQ-007 req0ValidIn/req1ValidIn  input  1  requester N has an operand.
REQ-008 req0DataIn/req1DataIn  input  DATA_WIDTH  requester N operand.
REQ-009 req0ReadyOut/req1ReadyOut  output  1  operand accepted this cycle when ANDed with valid.
REQ-010 pipeDataOut  output  DATA_WIDTH  operand driven to the datapath input.
REQ-011 pipeDataIn  input  DATA_WIDTH  datapath output.
REQ-012 rspValidOut  output  1  result available at the FIFO head.
REQ-013 rspDataOut  output  DATA_WIDTH  FIFO head result.
REQ-014 rspIdOut  output  1  requester index (0/1) that issued the head result.
REQ-015 rspReadyIn  input  1  consumer pops the head when ANDed with rspValidOut.
REQ-016 busyOut  output  1  high while any operand is in flight or any FIFO entry is held.

Function
REQ-017 Credit count SHALL equal in-flight operands plus FIFO occupancy; issue is permitted only when count < FIFO_DEPTH. A pop SHALL NOT free a credit until the following cycle.
REQ-018 Arbitration SHALL be round-robin. With both valids high, the requester not granted last wins. With one valid high, that requester wins. The last-granted pointer SHALL update only on an accepted transfer.
REQ-019 reqNReadyOut SHALL be high iff requester N wins arbitration and issue is permitted. It SHALL never be high for both requesters in the same cycle.
REQ-020 pipeDataOut SHALL equal the accepted operand in its accept cycle t, and 0 otherwise.
REQ-021 A LATENCY-stage shift register SHALL carry {valid, id} alongside the datapath, loaded in cycle t. Its final stage SHALL be valid in cycle t+LATENCY.
REQ-022 When the final stage is valid, pipeDataIn and the id SHALL be written to the FIFO at the end of that cycle.
REQ-023 rspValidOut SHALL rise no earlier than cycle t+LATENCY+1; with an empty FIFO it SHALL rise exactly then.
REQ-024 The FIFO SHALL be registered with no bypass and SHALL preserve issue order. Write and pop SHALL be allowed in the same cycle, with occupancy unchanged.
REQ-025 The credit rule SHALL guarantee the FIFO never overflows. A write to a full FIFO is a design error and SHALL be flagged by an assertion.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 Back-to-back accepts SHALL sustain one issue per cycle while credits remain.
REQ-028 rspDataOut and rspIdOut SHALL hold stable while rspValidOut is high and rspReadyIn is low.
REQ-029 busyOut SHALL be the registered-state OR of (any shift-stage valid) and (FIFO not empty).

Reset
REQ-030 While rstIn is low, the following SHALL hold:
- req0ReadyOut = req1ReadyOut = 0
- rspValidOut = 0
- rspDataOut = 0, rspIdOut = 0
- pipeDataOut = 0
- busyOut = 0
REQ-031 Reset SHALL clear all shift-stage valids, the FIFO pointers, occupancy and credits.
REQ-032 Reset SHALL set the round-robin pointer to "last granted = 1", so requester 0 wins first.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight and buffered results. Datapath output emerging after reset release SHALL be ignored, because its stage valids are clear.
REQ-034 The first issue SHALL be possible in the first cycle after rstIn deasserts.

Verification
REQ-035 Single issue: req0 sends 0xA5A5A5A5 at cycle t with rspReadyIn=1 -> rspValidOut=1 at t+9 with data 0xA5A5A5A5 and id 0, busyOut low from t+10.
REQ-036 Contention: both valids held high for 4 cycles -> grants alternate 0,1,0,1, and responses return in that id order.
REQ-037 Backpressure: rspReadyIn=0 with req0 valid continuously -> exactly 4 accepts, then ready stays 0. After one pop, one further accept occurs in the next cycle only.
REQ-038 Simultaneous write/pop: full-rate issue with rspReadyIn=1 -> the FIFO never exceeds 1 entry and all results arrive in order with no loss.
REQ-039 Mid-flight reset: rstIn pulsed low at t+3 after 3 issues -> no rspValidOut ever rises for those operands, and busyOut=0 after release.
REQ-040 Wrap: 3*FIFO_DEPTH sequential operands with random rspReadyIn -> every result is delivered exactly once, in order, with correct ids.
